// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  // Bit positions inside sram_ctl_n = {cs, we, oe, ub, lb}, all active-low
  localparam int CS = 4;
  localparam int WE = 3;
  localparam int OE = 2;
  localparam int UB = 1;
  localparam int LB = 0;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);

endpackage

// File: rtl/sram_arb_grant.sv
// One-hot grant for two requesters; on a tie the requester not granted last wins.
module sram_arb_grant (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for an async 16-bit SRAM: IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> DONE.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
import sram_arb_pkg::*;

module sram_arbiter #(
  parameter int WAIT_CYCLES = 2,  // legal range 1..WAIT_MAX
  parameter int ADDR_W      = 18
) (
  input  logic              CLK,
  input  logic              reset_in,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic [1:0]        ack,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [15:0]       sram_dat_read,
  output logic [15:0]       sram_dat_write,
  output logic              sram_dat_writeEnable,
  output logic [4:0]        sram_ctl_n
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       gnt, gnt_nxt;
  logic             t_we;
  logic [1:0]       t_be;
  logic [CNT_W-1:0] cnt;
  logic             last_gnt;
  logic             sel;

  sram_arb_grant u_grant (
    .req      (req),
    .last_gnt (last_gnt),
    .gnt      (gnt_nxt)
  );

  assign sel = gnt_nxt[1];

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in)                    last_gnt <= 1'b1;
    else if (state == IDLE && |req)  last_gnt <= sel;
  end
`else
  // Tie-break input pinned so requester 0 always wins
  assign last_gnt = 1'b1;
`endif

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      state          <= IDLE;
      gnt            <= '0;
      t_we           <= 1'b0;
      t_be           <= '0;
      cnt            <= '0;
      rdata          <= '0;
      sram_addr      <= '0;
      sram_dat_write <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|req) begin
          gnt            <= gnt_nxt;
          t_we           <= we[sel];
          t_be           <= sel ? be[3:2] : be[1:0];
          sram_addr      <= sel ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
          sram_dat_write <= sel ? wdata[31:16] : wdata[15:0];
        end
        SETUP: cnt <= CNT_LOAD;
        ACCESS: begin
          if (cnt == '0) rdata <= sram_dat_read;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Strobes are decoded from state so reset drops them in the same cycle
  always_comb begin
    state_nxt            = state;
    sram_ctl_n           = 5'b11111;
    sram_dat_writeEnable = 1'b0;
    ack                  = 2'b00;
    case (state)
      IDLE: if (|req) state_nxt = SETUP;
      SETUP: begin
        sram_ctl_n[CS]       = 1'b0;
        sram_ctl_n[OE]       = t_we;
        sram_ctl_n[UB]       = ~t_be[1];
        sram_ctl_n[LB]       = ~t_be[0];
        sram_dat_writeEnable = t_we;
        state_nxt            = ACCESS;
      end
      ACCESS: begin
        sram_ctl_n[CS]       = 1'b0;
        sram_ctl_n[WE]       = ~t_we;
        sram_ctl_n[OE]       = t_we;
        sram_ctl_n[UB]       = ~t_be[1];
        sram_ctl_n[LB]       = ~t_be[0];
        sram_dat_writeEnable = t_we;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        // Strobes released but data still driven for write hold time
        sram_ctl_n[CS]       = 1'b0;
        sram_ctl_n[UB]       = ~t_be[1];
        sram_ctl_n[LB]       = ~t_be[0];
        sram_dat_writeEnable = t_we;
        ack                  = gnt;
        state_nxt            = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed table, corner sequences, random traffic vs. a memory model.
module tb_sram_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int W  = 2;
  localparam int NV = 9;

  logic        CLK = 1'b0;
  logic        reset_in;
  logic [1:0]  req, we;
  logic [35:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic [1:0]  ack;
  logic [15:0] rdata, sram_dat_read = 16'h0, sram_dat_write;
  logic [17:0] sram_addr;
  logic        sram_dat_writeEnable;
  logic [4:0]  sram_ctl_n;

  logic [1:0]  w1_ack;
  logic [15:0] w1_rdata, w1_dat_read = 16'h0, w1_dat_write;
  logic [17:0] w1_addr;
  logic        w1_wen;
  logic [4:0]  w1_ctl_n;

  sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(18)) dut (
    .CLK(CLK), .reset_in(reset_in), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack), .rdata(rdata), .sram_addr(sram_addr), .sram_dat_read(sram_dat_read),
    .sram_dat_write(sram_dat_write), .sram_dat_writeEnable(sram_dat_writeEnable),
    .sram_ctl_n(sram_ctl_n)
  );

  sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(18)) dut_w1 (
    .CLK(CLK), .reset_in(reset_in), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(w1_ack), .rdata(w1_rdata), .sram_addr(w1_addr), .sram_dat_read(w1_dat_read),
    .sram_dat_write(w1_dat_write), .sram_dat_writeEnable(w1_wen), .sram_ctl_n(w1_ctl_n)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] sram_mem [int];
  logic [15:0] ref_mem  [int];
  bit          ref_last;

  function automatic logic [15:0] dflt(input int a);
    return a[15:0] ^ 16'h1357;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] b);
    merge = old;
    if (b[1]) merge[15:8] = d[15:8];
    if (b[0]) merge[7:0]  = d[7:0];
  endfunction

  function automatic logic [15:0] mem_rd(input int a);
    return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(int'(a));
  endfunction

  task automatic ref_write(input logic [17:0] a, input logic [15:0] d, input logic [1:0] b);
    ref_mem[int'(a)] = merge(ref_rd(a), d, b);
  endtask

  // SRAM device: outputs data while cs/oe are low, stores enabled bytes while cs/we are low
  always @(negedge CLK) begin
    sram_dat_read <= (!sram_ctl_n[4] && !sram_ctl_n[2]) ? mem_rd(int'(sram_addr)) : 16'h0;
    w1_dat_read   <= (!w1_ctl_n[4] && !w1_ctl_n[2]) ? mem_rd(int'(w1_addr)) : 16'h0;
  end
  always @(negedge CLK)
    if (!sram_ctl_n[4] && !sram_ctl_n[3])
      sram_mem[int'(sram_addr)] = merge(mem_rd(int'(sram_addr)), sram_dat_write, ~sram_ctl_n[1:0]);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [17:0] a0, input logic [17:0] a1,
                       input logic [31:0] d, input logic [3:0] b);
    req = r; we = w; addr = {a1, a0}; wdata = d; be = b;
  endtask

  function automatic logic [63:0] pins(input logic w);
    return 64'({ack, sram_ctl_n, sram_dat_writeEnable, sram_addr, w ? sram_dat_write : 16'h0});
  endfunction

  function automatic logic [17:0] pool(input int unsigned i);
    case (i)
      0:       return 18'h00123;
      1:       return 18'h3FFFF;
      2:       return 18'h00040;
      default: return 18'h00041;
    endcase
  endfunction

  // Called at the negedge where the request is presented in IDLE; walks SETUP..DONE and one IDLE cycle
  task automatic run_txn(input string nm, input logic [1:0] g, input logic w, input logic [17:0] a,
                         input logic [15:0] d, input logic [1:0] b, input logic [15:0] rd, input bit scr);
    logic [4:0] c;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge CLK);
      if (k == 1)          c = {1'b0, 1'b1, w, ~b};
      else if (k <= W + 1) c = {1'b0, ~w, w, ~b};
      else if (k == W + 2) c = {1'b0, 1'b1, 1'b1, ~b};
      else                 c = 5'b11111;
      chk($sformatf("%s k%0d", nm, k), pins(w),
          64'({(k == W + 2) ? g : 2'b00, c, (k <= W + 2) ? w : 1'b0, a, w ? d : 16'h0}));
      if (k == W + 2 && !w) chk({nm, " rdata"}, 64'(rdata), 64'(rd));
      if (scr && k <= W + 2)
        drive(2'($urandom), 2'($urandom), 18'($urandom), 18'($urandom), $urandom, 4'($urandom));
    end
  endtask

  typedef struct {
    logic [1:0]  req, we;
    logic [17:0] a0, a1;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [1:0]  gnt;
    logic [15:0] rd;
  } vec_t;
  vec_t tbl [NV];

  logic [1:0]  g, r, w;
  logic        s;
  logic [17:0] a0, a1, as;
  logic [31:0] d;
  logic [3:0]  b;
  int          gap;

  initial begin
    sram_mem[32'h123] = 16'hBEEF;
    ref_mem[32'h123]  = 16'hBEEF;
    ref_last = 1'b1;
    reset_in = 1'b1;
    drive(2'b00, 2'b00, 18'h0, 18'h0, 32'h0, 4'h0);

    tbl[0] = '{2'b01, 2'b00, 18'h00123, 18'h0,     32'h0,         4'b0011, 2'b01, 16'hBEEF};
    tbl[1] = '{2'b10, 2'b10, 18'h0,     18'h3FFFF, 32'hA55A_0000, 4'b1000, 2'b10, 16'h0};
    tbl[2] = '{2'b10, 2'b00, 18'h0,     18'h3FFFF, 32'h0,         4'b1100, 2'b10, 16'hA5A8};
    tbl[3] = '{2'b01, 2'b01, 18'h00123, 18'h0,     32'h0000_1111, 4'b0000, 2'b01, 16'h0};
    tbl[4] = '{2'b01, 2'b00, 18'h00123, 18'h0,     32'h0,         4'b0011, 2'b01, 16'hBEEF};
    tbl[5] = '{2'b11, 2'b00, 18'h00123, 18'h00123, 32'h0,         4'b1111, RR ? 2'b10 : 2'b01, 16'hBEEF};
    tbl[6] = '{2'b11, 2'b00, 18'h00123, 18'h00123, 32'h0,         4'b1111, 2'b01, 16'hBEEF};
    tbl[7] = '{2'b11, 2'b11, 18'h00040, 18'h00040, 32'h2222_1111, 4'b1111, RR ? 2'b10 : 2'b01, 16'h0};
    tbl[8] = '{2'b01, 2'b00, 18'h00040, 18'h0,     32'h0,         4'b0011, 2'b01, RR ? 16'h2222 : 16'h1111};

    @(negedge CLK); @(negedge CLK);
    chk("reset pins", pins(1'b1), 64'({2'b00, 5'b11111, 1'b0, 18'h0, 16'h0}));
    chk("reset rdata", 64'(rdata), 64'h0);

    // Request presented as reset falls; WAIT_CYCLES=1 copy acks one cycle earlier
    reset_in = 1'b0;
    drive(2'b01, 2'b00, 18'h00123, 18'h0, 32'h0, 4'b0011);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      chk($sformatf("latency w1 k%0d", k), 64'(w1_ack), 64'((k == 3) ? 2'b01 : 2'b00));
      chk($sformatf("latency w2 k%0d", k), 64'(ack), 64'((k == 4) ? 2'b01 : 2'b00));
      if (k == 3) chk("w1 rdata", 64'(w1_rdata), 64'h BEEF);
      if (k == 4) begin
        chk("w2 rdata", 64'(rdata), 64'hBEEF);
        req = 2'b00;
      end
    end
    @(negedge CLK);
    chk("idle hold", pins(1'b0), 64'({2'b00, 5'b11111, 1'b0, 18'h00123, 16'h0}));

    for (int i = 0; i < NV; i++) begin
      s = tbl[i].gnt[1];
      as = s ? tbl[i].a1 : tbl[i].a0;
      drive(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].wd, tbl[i].be);
      run_txn($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].we[s], as,
              s ? tbl[i].wd[31:16] : tbl[i].wd[15:0], s ? tbl[i].be[3:2] : tbl[i].be[1:0], tbl[i].rd, 1'b0);
      if (tbl[i].we[s]) ref_write(as, s ? tbl[i].wd[31:16] : tbl[i].wd[15:0], s ? tbl[i].be[3:2] : tbl[i].be[1:0]);
    end

    // Reset during the first ACCESS cycle of a write abandons it silently
    drive(2'b01, 2'b01, 18'h00777, 18'h0, 32'h0000_CAFE, 4'b0011);
    @(negedge CLK);
    chk("abort setup", 64'(sram_ctl_n), 64'(5'b01100));
    @(negedge CLK);
    chk("abort access", 64'(sram_ctl_n), 64'(5'b00100));
    reset_in = 1'b1;
    #1;
    chk("abort reset", pins(1'b1), 64'({2'b00, 5'b11111, 1'b0, 18'h0, 16'h0}));
    req = 2'b00;
    @(negedge CLK);
    reset_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      chk($sformatf("abort noack k%0d", k), 64'({ack, sram_ctl_n, sram_dat_writeEnable}),
          64'({2'b00, 5'b11111, 1'b0}));
    end
    ref_last = 1'b1;

    // Both requesters held high across acks
    drive(2'b11, 2'b00, 18'h00123, 18'h3FFFF, 32'h0, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      g = RR ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b01;
      as = g[1] ? 18'h3FFFF : 18'h00123;
      run_txn($sformatf("contend%0d", i), g, 1'b0, as, 16'h0, 2'b11, ref_rd(as), 1'b0);
    end
    ref_last = 1'b1;

    for (int t = 0; t < 40; t++) begin
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
        req = 2'b00;
        @(negedge CLK);
        chk("rnd gap", 64'({ack, sram_ctl_n, sram_dat_writeEnable}), 64'({2'b00, 5'b11111, 1'b0}));
      end
      r  = 2'($urandom_range(1, 3));
      w  = 2'($urandom);
      a0 = pool($urandom_range(0, 3));
      a1 = pool($urandom_range(0, 3));
      d  = $urandom;
      b  = 4'($urandom);
      drive(r, w, a0, a1, d, b);
      g  = (r == 2'b11) ? (RR ? (ref_last ? 2'b01 : 2'b10) : 2'b01) : r;
      s  = g[1];
      ref_last = s;
      as = s ? a1 : a0;
      run_txn($sformatf("rnd%0d", t), g, w[s], as, s ? d[31:16] : d[15:0], s ? b[3:2] : b[1:0], ref_rd(as), 1'b1);
      if (w[s]) ref_write(as, s ? d[31:16] : d[15:0], s ? b[3:2] : b[1:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: number of ACCESS-state cycles; legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 18: SRAM word-address width.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  2  per-requester access request, bit n = requester n.
REQ-006 SHALL have port we  input  2  per-requester write (1) / read (0).
REQ-007 SHALL have port addr  input  2*ADDR_W  requester n address at bits [n*ADDR_W +: ADDR_W].
REQ-008 SHALL have port wdata  input  32  requester n write data at bits [n*16 +: 16].
REQ-009 SHALL have port be  input  4  requester n byte enables at bits [n*2 +: 2], bit0 = low byte.
REQ-010 SHALL have port ack  output  2  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port rdata  output  16  read data, shared, valid while ack is high.
REQ-012 SHALL have port sram_addr  output  ADDR_W  address to SRAM pins.
REQ-013 SHALL have port sram_dat_read  input  16  data from bidirectional pad input.
REQ-014 SHALL have port sram_dat_write  output  16  data to bidirectional pad output.
REQ-015 SHALL have port sram_dat_writeEnable  output  1  pad output enable, active-high.
REQ-016 SHALL have port sram_ctl_n  output  5  active-low strobes {cs, we, oe, ub, lb}.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE.
REQ-018 IDLE: if any req bit is high, SHALL grant one requester, latch its we/addr/wdata/be, and go to SETUP; otherwise stay in IDLE.
REQ-019 SETUP (1 cycle): cs_n low, sram_addr valid; ub_n/lb_n = ~be; reads: oe_n low; writes: sram_dat_writeEnable high; we_n high.
REQ-020 ACCESS (WAIT_CYCLES cycles, down-counter): write: we_n low; read: oe_n low. SHALL capture sram_dat_read into rdata on the final ACCESS edge.
REQ-021 DONE (1 cycle): we_n and oe_n high, cs_n low, write data still driven (hold time); ack[grant] high; then go to IDLE.
REQ-022 Latency from req sampled in IDLE to ack high SHALL be exactly 2+WAIT_CYCLES cycles.
REQ-023 A requester SHALL drop req on the edge where it samples ack high; a req still high in IDLE SHALL start a new transaction.
REQ-024 req changes outside IDLE SHALL be ignored; latched transaction fields SHALL NOT change until IDLE.
REQ-025 In IDLE, sram_ctl_n SHALL be 5'b11111 and sram_dat_writeEnable 0; sram_addr/sram_dat_write hold their last values.
REQ-026 At most one ack bit SHALL be high in any cycle; ack SHALL never be high outside DONE.
REQ-027 be = 2'b00 SHALL still run the full sequence, with ub_n/lb_n high, and SHALL ack.

Reset
REQ-028 reset_in high SHALL immediately force IDLE, ack=0, rdata=0, sram_ctl_n=5'b11111, sram_dat_writeEnable=0, sram_addr=0, sram_dat_write=0, wait counter=0, last-grant=1; an in-flight access SHALL be abandoned without ack.
REQ-029 After reset_in falls, arbitration SHALL resume on the first CLK edge.

Configuration
REQ-030 With SRAM_ARB_RR_EN defined: round-robin; on simultaneous requests, grant the requester not granted last; last-grant updates on each grant.
REQ-031 Without SRAM_ARB_RR_EN: fixed priority, requester 0 always wins; last-grant register SHALL be absent.

Structure
REQ-032 Package sram_arb_pkg SHALL hold the FSM state enum, the strobe-bit index constants (CS, WE, OE, UB, LB), and the WAIT_CYCLES legal maximum.
REQ-033 One sub-module, sram_arb_grant, SHALL compute the one-hot grant from req and last-grant; the FSM and strobe timing stay in sram_arbiter.

Verification
REQ-034 Read: WAIT_CYCLES=2, req=01, we=0, addr0=0x00123, model returns 0xBEEF -> ack=01 exactly 4 cycles later, rdata=0xBEEF, oe_n low 3 cycles.
REQ-035 Write: req=10, we=10, addr1=0x3FFFF, wdata1=0xA55A, be1=10 -> we_n low 2 cycles, ub_n=0, lb_n=1, dat=0xA55A through DONE, ack=10.
REQ-036 Contention: req=11 held after each ack -> RR build: grants alternate 0,1,0,1; fixed build: only requester 0 served.
REQ-037 Reset mid-ACCESS: assert reset_in during a write -> same cycle sram_ctl_n=11111, writeEnable=0; no ack ever issued for that transaction.
REQ-038 Back-to-back: requester 0 keeps req high after ack -> next SETUP starts 2 cycles after ack; WAIT_CYCLES=1 gives 3-cycle latency.
